// File: rtl/if_prefetch.sv
// Instruction fetch: fetch PC, single-outstanding imem handshake, prefetch FIFO, IF/ID register.
// Optional IF_PREFETCH_BYPASS_EN: ack into an empty FIFO goes straight to IF/ID, back-to-back requests.
module if_prefetch #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd100
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc,
  output logic [31:0] dinst,
  output logic [31:0] dpc,
  output logic        dvalid
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d;
  logic [31:0]     pc_q, pc_d, addr_q, addr_d;
  logic            req_q, req_d;
  logic [31:0]     dinst_q, dinst_d, dpc_q, dpc_d;
  logic            dvalid_q, dvalid_d;
  logic            push, pop, byp, fifo_empty;
  logic [31:0]     inst_mem [DEPTH];
  logic [31:0]     ipc_mem  [DEPTH];

  assign fifo_empty = (count_q == '0);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    req_d    = req_q;
    dinst_d  = dinst_q;
    dpc_d    = dpc_q;
    dvalid_d = dvalid_q;
    push     = 1'b0;
    pop      = 1'b0;
    byp      = 1'b0;
    if (redirect) begin
      // Flush everything; an in-flight request must still be retired, so park it in DROP.
      count_d  = '0;
      rd_d     = '0;
      wr_d     = '0;
      dvalid_d = 1'b0;
      dinst_d  = '0;
      dpc_d    = '0;
      pc_d     = redirect_pc;
      if (state_q == WAIT || state_q == DROP) begin
        if (imem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end else begin
          state_d = DROP;
        end
      end
    end else begin
      case (state_q)
        IDLE: if (count_q < CW'(DEPTH)) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
        WAIT: if (imem_ack) begin
`ifdef IF_PREFETCH_BYPASS_EN
          byp = fifo_empty && !stall;
`endif
          push    = !byp;
          pc_d    = pc_q + 32'd4;
          state_d = IDLE;
          req_d   = 1'b0;
        end
        DROP: if (imem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
        default: state_d = IDLE;
      endcase
      if (!stall) begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          dinst_d  = inst_mem[rd_q];
          dpc_d    = ipc_mem[rd_q];
          dvalid_d = 1'b1;
        end else if (byp) begin
          dinst_d  = imem_rdata;
          dpc_d    = pc_q;
          dvalid_d = 1'b1;
        end else begin
          dinst_d  = '0;
          dpc_d    = '0;
          dvalid_d = 1'b0;
        end
      end
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
`ifdef IF_PREFETCH_BYPASS_EN
      if (state_q == WAIT && imem_ack && count_d < CW'(DEPTH)) begin
        state_d = WAIT;
        req_d   = 1'b1;
        addr_d  = pc_q + 32'd4;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      count_q  <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      pc_q     <= RESET_PC;
      addr_q   <= '0;
      req_q    <= 1'b0;
      dinst_q  <= '0;
      dpc_q    <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      dinst_q  <= dinst_d;
      dpc_q    <= dpc_d;
      dvalid_q <= dvalid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push) begin
      inst_mem[wr_q] <= imem_rdata;
      ipc_mem[wr_q]  <= pc_q;
    end
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign pc        = pc_q;
  assign dinst     = dinst_q;
  assign dpc       = dpc_q;
  assign dvalid    = dvalid_q;
endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: queue-based reference model checked every cycle, directed scenarios, random phase.
module tb_if_prefetch;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RSTPC = 32'd100;

  logic        clk = 1'b0, resetn = 1'b0;
  logic        imem_req, imem_ack = 1'b0, stall = 1'b0, redirect = 1'b0, dvalid;
  logic [31:0] imem_addr, imem_rdata = '0, redirect_pc = '0, pc, dinst, dpc;

  always #5 clk = ~clk;

  if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RSTPC)) dut (
    .clk(clk), .resetn(resetn), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .pc(pc), .dinst(dinst), .dpc(dpc), .dvalid(dvalid)
  );

  int errors = 0, checks = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fw(logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Reference model: the FIFO is a queue, the fetch unit is "outstanding" plus "wrong path".
  logic [31:0] m_pc, m_addr, m_dinst, m_dpc;
  bit          m_req, m_dv, m_out, m_drop;
  logic [63:0] m_q[$];

  task automatic model_step(bit rn, bit st, bit rd, logic [31:0] rpc, bit ak, logic [31:0] rdat);
    int n0;
    logic [63:0] e;
    n0 = m_q.size();
    if (!rn) begin
      m_pc = RSTPC; m_addr = '0; m_req = 0; m_out = 0; m_drop = 0;
      m_dinst = '0; m_dpc = '0; m_dv = 0; m_q.delete();
    end else if (rd) begin
      m_q.delete();
      m_dv = 0; m_dinst = '0; m_dpc = '0; m_pc = rpc;
      if (m_out) begin
        if (ak) begin m_out = 0; m_drop = 0; m_req = 0; end
        else m_drop = 1;
      end
    end else begin
      if (!st) begin
        if (n0 > 0) begin
          e = m_q.pop_front();
          m_dinst = e[63:32]; m_dpc = e[31:0]; m_dv = 1;
        end else begin
          m_dinst = '0; m_dpc = '0; m_dv = 0;
        end
      end
      if (m_out) begin
        if (ak) begin
          if (!m_drop) begin m_q.push_back({rdat, m_pc}); m_pc = m_pc + 32'd4; end
          m_out = 0; m_drop = 0; m_req = 0;
        end
      end else if (n0 < DEPTH) begin
        m_out = 1; m_req = 1; m_addr = m_pc;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(resetn, stall, redirect, redirect_pc, imem_ack, imem_rdata);
    #1;
    chk("pc", pc, m_pc);
    chk("imem_req", {31'd0, imem_req}, {31'd0, m_req});
    if (m_req) chk("imem_addr", imem_addr, m_addr);
    chk("dvalid", {31'd0, dvalid}, {31'd0, m_dv});
    chk("dinst", dinst, m_dinst);
    chk("dpc", dpc, m_dpc);
  end

  // Instruction memory: fixed or random latency, ack 0 means same cycle as the first req cycle.
  int wcnt = 0, cur_lat = 0, fix_lat = 0;
  bit rnd_lat = 0;
  always @(negedge clk) begin
    if (imem_req) begin
      if (wcnt == 0) cur_lat = rnd_lat ? int'($urandom_range(0, 3)) : fix_lat;
      if (wcnt >= cur_lat) begin
        imem_ack = 1'b1; imem_rdata = fw(imem_addr); wcnt = 0;
      end else begin
        imem_ack = 1'b0; imem_rdata = $urandom; wcnt++;
      end
    end else begin
      imem_ack = 1'b0; imem_rdata = $urandom; wcnt = 0;
    end
  end

  task automatic nxt();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0; nxt(); nxt(); resetn = 1'b1;
  endtask

  logic [31:0] seen_pc[$];
  logic [31:0] seen_in[$];
  int comps;
  bit found;

  initial begin
    // Reset state
    resetn = 1'b0; nxt(); nxt(); nxt();
    chk("rst_pc", pc, 32'd100);
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_dvalid", {31'd0, dvalid}, 32'd0);

    // Zero-wait memory, no stall
    fix_lat = 0; rnd_lat = 0;
    resetn = 1'b1; nxt();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd100);
    seen_pc.delete(); seen_in.delete();
    repeat (12) begin
      nxt();
      if (dvalid) begin seen_pc.push_back(dpc); seen_in.push_back(dinst); end
    end
    chk("zw_count", seen_pc.size(), 32'd6);
    for (int i = 0; i < 3 && i < seen_pc.size(); i++) begin
      chk("zw_dpc", seen_pc[i], 32'd100 + 32'(4 * i));
      chk("zw_dinst", seen_in[i], fw(32'd100 + 32'(4 * i)));
    end

    // Stall with fast memory: FIFO fills, then drains in order
    resetn = 1'b0; nxt();
    stall = 1'b1; resetn = 1'b1;
    comps = 0;
    repeat (10) begin
      nxt();
      if (imem_req && imem_ack) comps++;
    end
    chk("stall_comps", comps, DEPTH);
    chk("stall_req_off", {31'd0, imem_req}, 32'd0);
    chk("stall_dvalid", {31'd0, dvalid}, 32'd0);
    stall = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      nxt();
      chk("drain_dvalid", {31'd0, dvalid}, 32'd1);
      chk("drain_dpc", dpc, 32'd100 + 32'(4 * i));
    end

    // 3-cycle latency: sequential, no loss or duplication
    fix_lat = 3;
    do_reset();
    seen_pc.delete();
    repeat (40) begin
      nxt();
      if (dvalid) seen_pc.push_back(dpc);
    end
    chk("lat3_some", {31'd0, seen_pc.size() > 3}, 32'd1);
    for (int i = 0; i < seen_pc.size(); i++) chk("lat3_seq", seen_pc[i], 32'd100 + 32'(4 * i));

    // Redirect while the 0x10C fetch is outstanding
    do_reset();
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      nxt();
      if (imem_req && imem_addr == 32'h10C && !imem_ack) found = 1;
    end
    chk("redir_found", {31'd0, found}, 32'd1);
    redirect = 1'b1; redirect_pc = 32'h200; nxt(); redirect = 1'b0;
    chk("redir_dvalid", {31'd0, dvalid}, 32'd0);
    chk("redir_pc", pc, 32'h200);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (imem_req && imem_addr != 32'h10C) found = 1;
      else nxt();
    end
    chk("redir_req_found", {31'd0, found}, 32'd1);
    chk("redir_addr", imem_addr, 32'h200);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      nxt();
      if (dvalid) found = 1;
    end
    chk("redir_dv_found", {31'd0, found}, 32'd1);
    chk("redir_dpc", dpc, 32'h200);
    chk("redir_dinst", dinst, fw(32'h200));

    // Redirect, stall and ack in the same cycle
    fix_lat = 0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (imem_req && imem_ack) found = 1;
      else nxt();
    end
    chk("rsa_found", {31'd0, found}, 32'd1);
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h301; nxt();
    redirect = 1'b0; stall = 1'b0;
    chk("rsa_pc", pc, 32'h301);
    chk("rsa_dvalid", {31'd0, dvalid}, 32'd0);
    chk("rsa_dinst", dinst, 32'd0);
    chk("rsa_req", {31'd0, imem_req}, 32'd0);

    // Reset during WAIT, stray ack right after release
    fix_lat = 3;
    do_reset();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      nxt();
      if (imem_req && !imem_ack) found = 1;
    end
    chk("rw_found", {31'd0, found}, 32'd1);
    resetn = 1'b0; nxt();
    resetn = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      nxt();
      if (dvalid) found = 1;
    end
    chk("rw_dv_found", {31'd0, found}, 32'd1);
    chk("rw_dpc", dpc, 32'd100);
    chk("rw_dinst", dinst, fw(32'd100));

    // Random traffic
    rnd_lat = 1;
    repeat (2000) begin
      stall       = ($urandom_range(0, 9) < 3);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = $urandom;
      resetn      = ($urandom_range(0, 149) != 0);
      nxt();
    end
    stall = 1'b0; redirect = 1'b0; resetn = 1'b1;
    nxt(); nxt();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/if_prefetch.md
# if_prefetch

Instruction-fetch stage of the 5-stage pipelined datapath: owns the fetch PC, issues word reads to instruction memory over a req/ack handshake, buffers returned words in a small prefetch FIFO, and drives the IF/ID pipeline register consumed by decode (`dinst`/`dpc`). It absorbs variable instruction-memory latency and decode stalls, and discards wrong-path fetches on a branch/jump redirect from decode.

## Interface
- `DEPTH`, 4, prefetch FIFO entries (power of two, 2..16)
- `RESET_PC`, 32'd100, fetch address after reset
- `clk`  in  1  clock, all state updates on rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `imem_req`  out  1  read request to instruction memory
- `imem_addr`  out  32  word address of the request
- `imem_ack`  in  1  read data valid, completes the request
- `imem_rdata`  in  32  instruction word, valid when `imem_ack`
- `stall`  in  1  decode stall; IF/ID register holds
- `redirect`  in  1  branch/jump taken; flush and refetch
- `redirect_pc`  in  32  new fetch address, valid with `redirect`
- `pc`  out  32  current fetch PC
- `dinst`  out  32  IF/ID instruction
- `dpc`  out  32  IF/ID instruction address
- `dvalid`  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Fetch FSM states: IDLE (no request), WAIT (request outstanding), DROP (outstanding request belongs to flushed path).
- IDLE -> WAIT when `count + 0 < DEPTH` (free slot) and no `redirect`; `imem_req`=1, `imem_addr`=`pc`.
- WAIT: `imem_req` and `imem_addr` held stable until `imem_ack`. On ack: push {`imem_rdata`, `pc`} into FIFO, `pc` <= `pc`+4 (wraps mod 2^32), go IDLE. At most one request outstanding.
- DROP: `imem_req` held until `imem_ack`; returned word discarded, `pc` unchanged, go IDLE.
- IF/ID register: if `stall`=0, load FIFO head (pop) with `dvalid`=1, or load `dinst`=0, `dpc`=0, `dvalid`=0 if FIFO empty. If `stall`=1, hold all three.
- `redirect` (priority over `stall` and ack): FIFO cleared, `dvalid`<=0, `dinst`<=0, `pc`<=`redirect_pc`; WAIT -> DROP (ack in the same cycle completes the drop and returns to IDLE); IDLE stays IDLE, new request starts next cycle.
- Push and pop in the same cycle with FIFO full or empty are legal; count is unchanged when both occur. Push never occurs when full (request gating guarantees it).
- `redirect_pc` is not alignment-checked; low two bits are passed through.

## Timing
- Reset (`resetn`=0 at an edge): `pc`=`RESET_PC`, state IDLE, FIFO empty, `imem_req`=0, `imem_addr`=0, `dinst`=0, `dpc`=0, `dvalid`=0. Reset mid-request abandons it; any later ack while IDLE is ignored.
- First `imem_req` high in the first cycle after `resetn` rises.
- Latency (bypass off): ack at edge N -> word in FIFO after N -> in IF/ID (`dvalid`=1) after edge N+1 if not stalled.
- Zero-wait memory (ack in first req cycle): one instruction per 2 cycles, since IDLE is visited between requests.
- After `redirect` at edge R: `dvalid`=0 from R; first redirected request issued in cycle after R (IDLE) or after the in-flight ack (DROP).

## Configuration
- `IF_PREFETCH_BYPASS_EN`: when defined, an ack arriving while FIFO empty, `stall`=0 and not DROP writes directly into IF/ID at that edge (`dvalid`=1 after edge N) instead of the FIFO; also WAIT -> WAIT back-to-back on ack when a slot remains, giving one instruction per cycle with zero-wait memory. When undefined, behaviour is exactly as above.

## Test plan
- Reset release, memory acks every request in the same cycle, no stall -> `imem_addr` 100, 104, 108...; `dpc` sequence 100, 104, 108 with matching `dinst`, `dvalid` alternating per throughput rule.
- `stall`=1 for 10 cycles with fast memory -> exactly `DEPTH`=4 requests complete, `imem_req` then stays 0; IF/ID unchanged; on release, 4 words drain in consecutive cycles in order.
- Memory with 3-cycle ack latency -> `imem_addr` stable for all 3 req cycles; no lost or duplicated `dpc`.
- `redirect` to 0x200 while request to 0x10C outstanding -> 0x10C word dropped, FIFO flushed, `dvalid`=0, next issued address 0x200, next valid `dpc`=0x200.
- `redirect` and `stall` and `imem_ack` in the same cycle -> redirect wins: flush, ack word discarded, `pc`=`redirect_pc`.
- `resetn` low during WAIT, late ack after release -> ignored; first valid `dpc`=100.
